// File: rtl/arp_req_arbiter_if.sv
// arp_req_arbiter_if: requester-side and arp-side handshake bundle for arp_req_arbiter
//   req_valid/req_ready/req_ip         per-requester lookup request channel
//   resp_valid/resp_ready              per-requester response channel
//   resp_error/resp_mac                shared response payload
//   arp_request_*/arp_response_*       single port toward the arp block
//   slave modport = arbiter view, master modport = requester/arp side view
interface arp_req_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_ip;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic                  resp_error;
  logic [47:0]           resp_mac;
  logic                  arp_request_valid;
  logic                  arp_request_ready;
  logic [31:0]           arp_request_ip;
  logic                  arp_response_valid;
  logic                  arp_response_ready;
  logic                  arp_response_error;
  logic [47:0]           arp_response_mac;
  modport slave (
    input  req_valid, req_ip, resp_ready, arp_request_ready,
           arp_response_valid, arp_response_error, arp_response_mac,
    output req_ready, resp_valid, resp_error, resp_mac,
           arp_request_valid, arp_request_ip, arp_response_ready
  );
  modport master (
    output req_valid, req_ip, resp_ready, arp_request_ready,
           arp_response_valid, arp_response_error, arp_response_mac,
    input  req_ready, resp_valid, resp_error, resp_mac,
           arp_request_valid, arp_request_ip, arp_response_ready
  );
endinterface

// File: rtl/arp_req_arbiter.sv
// arp_req_arbiter: round-robin sharing of one arp lookup port among NUM_REQ requesters
//   clk, rst_n (async active-low)   clock and reset
//   bus (arp_req_arbiter_if.slave)  requester channels and arp port
//   grant_id_o                      current or last granted requester
//   busy_o                          high whenever a lookup is in flight
//   Optional ARP_ARB_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES with stale-response drain
module arp_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arp_req_arbiter_if.slave     bus,
  output logic [SEL_WIDTH-1:0] grant_id_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   rr_q, rr_d, grant_q, grant_d, win, idx;
  logic [31:0]            ip_q, ip_d, win_ip;
  logic [47:0]            mac_q, mac_d;
  logic                   err_q, err_d, hit;
`ifdef ARP_ARB_TIMEOUT_EN
  logic [31:0]            cnt_q, cnt_d;
  logic                   stale_q, stale_d;
`endif
  // Scan from the farthest offset down so the nearest requester after rr_q wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = SEL_WIDTH'((int'(rr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    win_ip = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (SEL_WIDTH'(i) == win) win_ip = bus.req_ip[32*i +: 32];
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    ip_d    = ip_q;
    mac_d   = mac_q;
    err_d   = err_q;
`ifdef ARP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    stale_d = stale_q;
    // Outside WAIT a stale response is swallowed by the drain.
    if (state_q != WAIT && stale_q && bus.arp_response_valid) stale_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (hit) begin
        state_d = ISSUE;
        grant_d = win;
        ip_d    = win_ip;
      end
      ISSUE: if (bus.arp_request_ready) begin
        state_d = WAIT;
`ifdef ARP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
`ifdef ARP_ARB_TIMEOUT_EN
        if (bus.arp_response_valid && stale_q) begin
          stale_d = 1'b0;
          cnt_d   = '0;
        end else if (bus.arp_response_valid) begin
          state_d = RETURN;
          mac_d   = bus.arp_response_mac;
          err_d   = bus.arp_response_error;
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = RETURN;
          mac_d   = '0;
          err_d   = 1'b1;
          stale_d = 1'b1;
        end else cnt_d = cnt_q + 32'd1;
`else
        if (bus.arp_response_valid) begin
          state_d = RETURN;
          mac_d   = bus.arp_response_mac;
          err_d   = bus.arp_response_error;
        end
`endif
      end
      RETURN: if (bus.resp_ready[grant_q]) begin
        state_d = IDLE;
        rr_d    = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= SEL_WIDTH'(NUM_REQ - 1);
      grant_q <= '0;
      ip_q    <= '0;
      mac_q   <= '0;
      err_q   <= 1'b0;
`ifdef ARP_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      stale_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ip_q    <= ip_d;
      mac_q   <= mac_d;
      err_q   <= err_d;
`ifdef ARP_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
`endif
    end
  end
  assign bus.req_ready         = (state_q == IDLE && hit) ? NUM_REQ'(1) << win : '0;
  assign bus.resp_valid        = (state_q == RETURN) ? NUM_REQ'(1) << grant_q : '0;
  assign bus.resp_mac          = mac_q;
  assign bus.resp_error        = err_q;
  assign bus.arp_request_valid = state_q == ISSUE;
  assign bus.arp_request_ip    = ip_q;
`ifdef ARP_ARB_TIMEOUT_EN
  assign bus.arp_response_ready = state_q == WAIT || stale_q;
`else
  assign bus.arp_response_ready = state_q == WAIT;
`endif
  assign grant_id_o = grant_q;
  assign busy_o     = state_q != IDLE;
endmodule

// File: tb/tb_arp_req_arbiter.sv
// tb_arp_req_arbiter: vector table, directed corner sequences and randomized transactions vs a grant model
module tb_arp_req_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant_id;
  logic busy;
  int tests = 0;
  int fails = 0;
  int rr = N - 1;
  always #5 clk = ~clk;
  arp_req_arbiter_if #(.NUM_REQ(N)) bus();
  arp_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant_id_o(grant_id), .busy_o(busy)
  );
  typedef struct {
    logic [N-1:0] mask;
    logic [31:0]  ip;
    int           acc_d;
    int           rsp_d;
    int           rdy_d;
    logic [47:0]  mac;
    logic         err;
    int           g;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Next owner: first requesting index after the last grant, wrapping around.
  function automatic int pick(input logic [N-1:0] m, input int r);
    for (int k = 1; k <= N; k++) if (m[(r + k) % N]) return (r + k) % N;
    return 0;
  endfunction
  task automatic txn(input logic [N-1:0] mask, input logic [31:0] ip, input int acc_d,
                     input int rsp_d, input int rdy_d, input logic [47:0] mac,
                     input logic err, input int g);
    logic [N-1:0] own;
    own = N'(1) << g;
    for (int i = 0; i < N; i++) bus.req_ip[32*i +: 32] = $urandom;
    bus.req_ip[32*g +: 32] = ip;
    bus.req_valid = mask;
    #1;
    chk("req_ready", bus.req_ready, own);
    step();
    bus.req_valid = mask & ~own;
    bus.req_ip = '0;
    chk("arp_req_valid", bus.arp_request_valid, 1);
    chk("arp_req_ip", bus.arp_request_ip, ip);
    chk("grant_id", grant_id, g);
    chk("busy", busy, 1);
    chk("issue_rsp_ready", bus.arp_response_ready, 0);
    for (int c = 0; c < acc_d; c++) begin
      step();
      chk("issue_hold_valid", bus.arp_request_valid, 1);
      chk("issue_hold_ip", bus.arp_request_ip, ip);
      chk("issue_no_grant", bus.req_ready, 0);
    end
    bus.arp_request_ready = 1'b1;
    step();
    bus.arp_request_ready = 1'b0;
    chk("arp_req_drop", bus.arp_request_valid, 0);
    chk("wait_rsp_ready", bus.arp_response_ready, 1);
    for (int c = 0; c < rsp_d; c++) begin
      step();
      chk("wait_no_resp", bus.resp_valid, 0);
      chk("wait_rsp_ready", bus.arp_response_ready, 1);
    end
    bus.arp_response_valid = 1'b1;
    bus.arp_response_mac = mac;
    bus.arp_response_error = err;
    step();
    bus.arp_response_valid = 1'b0;
    bus.arp_response_mac = 48'({$urandom, $urandom});
    bus.arp_response_error = ~err;
    chk("resp_valid", bus.resp_valid, own);
    chk("resp_mac", bus.resp_mac, mac);
    chk("resp_error", bus.resp_error, err);
    chk("ret_rsp_ready", bus.arp_response_ready, 0);
    for (int c = 0; c < rdy_d; c++) begin
      bus.resp_ready = ~own;
      step();
      chk("ret_hold_valid", bus.resp_valid, own);
      chk("ret_hold_mac", bus.resp_mac, mac);
      chk("ret_no_grant", bus.req_ready, 0);
    end
    bus.resp_ready = own;
    bus.req_valid = '0;
    step();
    bus.resp_ready = '0;
    chk("resp_done", bus.resp_valid, 0);
    chk("idle", busy, 0);
    rr = g;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int g;
    logic [N-1:0] m;
    bus.req_valid = '0;
    bus.req_ip = '0;
    bus.resp_ready = '0;
    bus.arp_request_ready = 1'b0;
    bus.arp_response_valid = 1'b0;
    bus.arp_response_error = 1'b0;
    bus.arp_response_mac = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_req_valid", bus.arp_request_valid, 0);
    chk("rst_req_ip", bus.arp_request_ip, 0);
    chk("rst_rsp_ready", bus.arp_response_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_mac", bus.resp_mac, 0);
    chk("rst_resp_err", bus.resp_error, 0);
    rst_n = 1'b1;
    step();
    tbl[0] = '{4'b1111, 32'h0a000001, 0, 0, 0, 48'h111111111111, 1'b0, 0};
    tbl[1] = '{4'b1111, 32'h0a000002, 0, 0, 0, 48'h222222222222, 1'b0, 1};
    tbl[2] = '{4'b1111, 32'h0a000003, 0, 0, 0, 48'h333333333333, 1'b1, 2};
    tbl[3] = '{4'b1111, 32'h0a000004, 0, 0, 0, 48'h444444444444, 1'b0, 3};
    tbl[4] = '{4'b1111, 32'h0a000005, 0, 0, 0, 48'h555555555555, 1'b0, 0};
    tbl[5] = '{4'b0001, 32'hc0a80166, 0, 3, 0, 48'h5a5152535455, 1'b0, 0};
    tbl[6] = '{4'b0100, 32'hc0a80240, 0, 1, 0, 48'h0a0b0c0d0e0f, 1'b1, 2};
    tbl[7] = '{4'b0010, 32'hc0a80111, 5, 2, 4, 48'h001122334455, 1'b0, 1};
    tbl[8] = '{4'b1001, 32'hc0a80177, 1, 0, 1, 48'hdeadbeef0001, 1'b0, 3};
    tbl[9] = '{4'b1001, 32'hc0a80188, 0, 2, 2, 48'hdeadbeef0002, 1'b1, 0};
    for (int v = 0; v < 10; v++)
      txn(tbl[v].mask, tbl[v].ip, tbl[v].acc_d, tbl[v].rsp_d, tbl[v].rdy_d,
          tbl[v].mac, tbl[v].err, tbl[v].g);
    // Reset while waiting on the arp block: everything clears, priority restarts at 0.
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    chk("mid_grant", grant_id, 2);
    bus.arp_request_ready = 1'b1;
    step();
    bus.arp_request_ready = 1'b0;
    chk("mid_wait", bus.arp_response_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_grant", grant_id, 0);
    chk("mrst_req_ip", bus.arp_request_ip, 0);
    chk("mrst_rsp_ready", bus.arp_response_ready, 0);
    chk("mrst_resp_mac", bus.resp_mac, 0);
    chk("mrst_resp_err", bus.resp_error, 0);
    chk("mrst_resp_valid", bus.resp_valid, 0);
    step();
    rst_n = 1'b1;
    rr = N - 1;
    txn(4'b1111, 32'h01020304, 0, 1, 0, 48'hcafe00000001, 1'b0, 0);
    for (int t = 0; t < 40; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      g = pick(m, rr);
      txn(m, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
          48'({$urandom, $urandom}), 1'($urandom_range(0, 1)), g);
    end
`ifdef ARP_ARB_TIMEOUT_EN
    g = pick(4'b0010, rr);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    chk("to_grant", grant_id, g);
    bus.arp_request_ready = 1'b1;
    step();
    bus.arp_request_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      chk("to_pending", bus.resp_valid, 0);
    end
    step();
    chk("to_resp_valid", bus.resp_valid, N'(1) << g);
    chk("to_resp_err", bus.resp_error, 1);
    chk("to_resp_mac", bus.resp_mac, 0);
    chk("to_drain_ready", bus.arp_response_ready, 1);
    bus.arp_response_valid = 1'b1;
    bus.arp_response_mac = 48'habcdefabcdef;
    step();
    bus.arp_response_valid = 1'b0;
    chk("to_drained_mac", bus.resp_mac, 0);
    chk("to_drain_done", bus.arp_response_ready, 0);
    bus.resp_ready = N'(1) << g;
    step();
    bus.resp_ready = '0;
    chk("to_release", bus.resp_valid, 0);
    rr = g;
    txn(4'b0001, 32'h0a0b0c0d, 0, 2, 0, 48'h0000feed0001, 1'b0, pick(4'b0001, rr));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arp_req_arbiter.md
Name: arp_req_arbiter

Overview:
- Shares the single ARP request/response port of the arp block among NUM_REQ independent requesters, such as IP TX paths and a management core.
- Round-robin grant; exactly one lookup outstanding at a time.
- Latches the winner's IP, drives the arp request handshake, waits for the response, then routes MAC/error back to the granted requester only.
- Sits between the requesters and arp_inst, clocked with it.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- SEL_WIDTH, $clog2(NUM_REQ): grant index width.
- TIMEOUT_CYCLES, 1024: WAIT-state watchdog limit in cycles. Used only with ARP_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_ip  in  NUM_REQ*32  packed IPs; requester i uses bits [32*i+31:32*i].
- resp_valid  out  NUM_REQ  per-requester response, one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_error  out  1  error flag of the current response.
- resp_mac  out  48  MAC of the current response.
- arp_request_valid  out  1  to arp block.
- arp_request_ready  in  1  from arp block.
- arp_request_ip  out  32  to arp block.
- arp_response_valid  in  1  from arp block.
- arp_response_ready  out  1  to arp block.
- arp_response_error  in  1  from arp block.
- arp_response_mac  in  48  from arp block.
- grant_id  out  SEL_WIDTH  index of the current or last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including arp_request_ip, resp_mac, grant_id.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it silently; no response is issued.
- States: IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - Winner = first i with req_valid[i], scanning rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 is combinational, gated by state==IDLE; all other bits are 0.
  - On transfer: latch arp_request_ip=req_ip[winner], grant_id=winner, arp_request_valid<=1; go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - arp_request_valid held at 1; IP held stable.
  - On arp_request_ready: arp_request_valid<=0, arp_response_ready<=1; go to WAIT.
- WAIT:
  - arp_response_ready=1.
  - On arp_response_valid: latch resp_mac/resp_error, arp_response_ready<=0, resp_valid[grant_id]<=1; go to RETURN.
- RETURN:
  - resp_valid[grant_id] held with mac/error stable.
  - On resp_ready[grant_id]: resp_valid<=0, rr_ptr<=grant_id; go to IDLE.
  - resp_ready on other bits is ignored.
- Latency:
  - req transfer at cycle 0 gives arp_request_valid high at cycle 1.
  - arp response transfer at cycle k gives resp_valid at cycle k+1.
  - Best case is back-to-back grants with one IDLE cycle between transactions.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- A requester may drop req_valid before it is granted; it is simply skipped.
- Simultaneous arp_request_ready and arp_response_valid in ISSUE: the response is not accepted in ISSUE (arp_response_ready=0); it is taken in WAIT.
- arp_response_ready is 0 outside WAIT unless the stale drain under ARP_ARB_TIMEOUT_EN is active.

Optional Feature:
- Macro: ARP_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a response: resp_error<=1, resp_mac<=0, resp_valid[grant_id]<=1, stale<=1; go to RETURN.
  - While stale=1, arp_response_ready=1 in every state except WAIT. The first arp response accepted this way is discarded and clears stale.
  - If stale=1 when WAIT is next entered, the first response in WAIT is dropped, stale clears, and the watchdog restarts.
  - stale resets to 0.
- When undefined: WAIT waits indefinitely; no counter or stale logic is present.

Test Plan:
- Single lookup: req_valid=0001, req_ip[0]=c0a80166. Bench arp accepts and responds 3 cycles later with mac=5a5152535455, error=0 -> arp_request_ip=c0a80166; resp_valid=0001 one cycle after arp response, resp_mac=5a5152535455, resp_error=0, grant_id=0.
- Round-robin: req_valid=1111 held, responses immediate -> grant order 0,1,2,3,0; each requester sees resp_valid only on its own bit.
- Error path: req from requester 2, ip=c0a80240; arp returns error=1 -> resp_valid=0100, resp_error=1.
- Backpressure: arp_request_ready low 5 cycles, then resp_ready[1] low 4 cycles -> arp_request_valid/ip and resp_valid/mac held stable; no new grant until resp_ready.
- Reset mid-WAIT: rst_n=0 for 1 cycle -> all outputs 0 immediately; busy=0; next grant goes to requester 0.
- ARP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: no arp response -> resp_valid with error=1, mac=0 at 16 cycles after WAIT entry; a late response is then drained with arp_response_ready=1 and never reaches a requester.
